// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART receive path.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } rx_state_e;

    function automatic int calc_cpb(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half(input int clk_freq, input int baud);
        return calc_cpb(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO; a push into a full FIFO only lands when a pop frees the slot.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a small FIFO, with sticky
// framing-error and overrun flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 40000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int CPB  = calc_cpb(CLK_FREQ, BAUD);
    localparam int HALF = calc_half(CLK_FREQ, BAUD);
    localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int BW   = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   rx_meta_q, rx_s_q;
    logic                   frame_err_q, overrun_q;
    logic                   push;
    logic                   frame_set;
    logic                   overrun_set;
    logic                   fifo_empty;
    logic                   fifo_full;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BRK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BRK_WAIT: begin
                // Hold off until the line is released so a break is not read as a start bit.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (shift_q),
        .pop        (rx_ready),
        .head       (rx_data),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .level      (fifo_level)
    );

    assign overrun_set = push && fifo_full && !rx_ready;

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err_q <= 1'b1;
            end else if (err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_valid  = !fifo_empty;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Synthesizable SoC-side UART receiver. It is the counterpart of the bench's 9600-baud serial transmitter: it deserializes 8N1 frames arriving on `rx` and buffers the bytes in a small FIFO. Bytes are read through a valid/ready handshake. Framing errors and overruns are reported as sticky flags to the register/Wishbone wrapper.

Parameters:
- CLK_FREQ, 40000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- rx, input, 1, serial line; idles high; asynchronous to clk.
- rx_data, output, 8, FIFO head byte; valid only while rx_valid is high.
- rx_valid, output, 1, FIFO not empty.
- rx_ready, input, 1, consumer pop; a pop occurs when rx_valid && rx_ready.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, current number of stored bytes.
- busy, output, 1, high whenever the FSM is not in IDLE.
- frame_err, output, 1, sticky; stop bit was sampled low.
- overrun, output, 1, sticky; a byte was dropped because the FIFO was full.
- err_clr, input, 1, single-cycle pulse that clears frame_err and overrun.

Behaviour:
- Constants:
  - CPB = CLK_FREQ/BAUD, integer division (4166 at the defaults).
  - HALF = CPB/2 (2083).
  - The bit counter is wide enough for CPB-1.
- Synchronizer: `rx` passes through a 2-flop synchronizer that resets to 1. All FSM decisions use the synchronized value rx_s, which lags `rx` by 2 cycles.
- Reset values:
  - FSM in IDLE; counters 0; shift register 0.
  - FIFO empty: rx_valid=0, fifo_level=0, rx_data=0.
  - busy=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame entirely; no partial byte is pushed.
- FSM states:
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: count to HALF-1.
    - If rx_s==0 at that point, go to DATA with cnt=0 and bit_idx=0.
    - Otherwise the low was a glitch: return to IDLE, push nothing, set no flag.
  - DATA: at cnt==CPB-1, shift right with rx_s entering bit 7 (LSB first), then cnt=0 and bit_idx+1. After sampling bit_idx==7, go to STOP.
  - STOP: at cnt==CPB-1, sample the stop bit.
    - rx_s==1: push the byte and go to IDLE.
    - rx_s==0: set frame_err, discard the byte, and go to BRK_WAIT.
  - BRK_WAIT: stay until rx_s==1, then go to IDLE. This prevents a held-low line (break) from being re-read as a start bit.
- Sampling: every bit, including the stop bit, is sampled at its nominal midpoint, i.e. HALF + k*CPB cycles after the falling edge is seen on rx_s.
- Push latency: the push happens at the stop-bit sample clock edge. rx_valid rises on the next cycle if the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through; rx_data always shows the head entry.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full, push, no pop: byte dropped, FIFO contents unchanged, overrun set.
  - Full, push and pop in the same cycle: both occur, level stays FIFO_DEPTH, no overrun.
  - Empty, pop requested: ignored, because rx_valid=0.
  - Push and pop on a non-full FIFO: level unchanged.
- Sticky flags: err_clr clears both flags. If err_clr coincides with a new set event, the set wins.
- busy is decoded combinationally from the state: state != IDLE.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE=0, START=1, DATA=2, STOP=3, BRK_WAIT=4, 3-bit encoding.
  - Localparam function computing CPB/HALF from CLK_FREQ and BAUD.
  - DATA_BITS=8.
- Sub-module uart_rx_fifo, parameterized by FIFO_DEPTH. Ports: push, push_data, pop, head, empty, full, level. This sub-module is also to be reused by the future TX path.

Test Plan:
1. Idle line, then 0x55 at 104166 ns/bit → rx_valid=1 with rx_data=0x55 one cycle after the stop-bit midpoint; fifo_level=1; no flags; busy returns to 0.
2. Glitch of `rx` low for 1000 cycles (< HALF), then high → FSM returns to IDLE, rx_valid stays 0, no flags set.
3. Frame 0xA3 with the stop bit driven low, then `rx` held low for 3 bit times → no push, frame_err=1, no new frame decoded until `rx` goes high. Then send 0x3C → 0x3C received correctly. err_clr pulse → frame_err=0.
4. Send 0x01, 0x02, 0x03, 0x04, 0x05 with rx_ready=0 → fifo_level=4, overrun=1. Popping yields 0x01–0x04 in order, and rx_valid=0 after the fourth pop.
5. FIFO full with rx_ready=1 held exactly on the push cycle of a fifth byte 0x99 → head 0x01 popped, 0x99 stored, fifo_level stays 4, overrun stays 0.
6. Assert rst_n low for 10 cycles during data bit 4 of 0xF0 → all outputs return to reset values. After release, 0x0F received correctly with no flags.
